// File: rtl/clock_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : clock_monitor
//  Brief    : Measures period/high time of an asynchronous clock and flags
//             out-of-range periods, short phases, stuck clocks; reports lock.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_monitor #(
   parameter int STAGES    = 2,
   parameter int CW        = 16,
   parameter int MIN_PHASE = 2,
   parameter int LOCK_N    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mon,
   input  logic          enable,
   input  logic          clear,
   input  logic [CW-1:0] per_min,
   input  logic [CW-1:0] per_max,
   output logic [CW-1:0] period,
   output logic [CW-1:0] high_cnt,
   output logic          meas_valid,
   output logic          err_period,
   output logic          err_glitch,
   output logic          err_stuck,
   output logic          locked
);

   localparam int GW = $clog2(LOCK_N + 1);

   localparam logic [CW-1:0] c_cnt_max   = '1;
   localparam logic [CW-1:0] c_cnt_one   = CW'(1);
   localparam logic [CW-1:0] c_min_phase = CW'(MIN_PHASE);
   localparam logic [GW-1:0] c_lock_n    = GW'(LOCK_N);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_arm  = 2'd1;
   localparam logic [1:0] c_meas = 2'd2;

   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   logic              w_sync;
   logic              w_rise;
   logic              w_fall;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              w_active;
   logic              w_in_meas;

   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     r_phase_lo;
   logic              r_hi_ok;
   logic              r_lo_ok;
   logic [GW-1:0]     r_good;

   logic [CW-1:0]     r_period;
   logic [CW-1:0]     r_high;
   logic              r_meas_valid;
   logic              r_err_period;
   logic              r_err_glitch;
   logic              r_err_stuck;

   logic [CW:0]       w_stuck_lim;
   logic              w_ev_period;
   logic              w_ev_glitch;
   logic              w_ev_stuck;
   logic              w_ev_any;
   logic              w_good_rise;

   assign w_sync = r_sync[STAGES-1];
   assign w_rise = w_sync & ~r_prev;
   assign w_fall = ~w_sync & r_prev;

   // A phase is only judged once its starting edge was actually observed,
   // otherwise the first edge after enabling would look like a glitch.
   assign w_stuck_lim = {per_max, 1'b0};
   assign w_ev_period = w_in_meas & w_rise & ((r_cnt < per_min) | (r_cnt > per_max));
   assign w_ev_glitch = w_active &
                        ((w_fall & r_hi_ok & (r_cnt < c_min_phase)) |
                         (w_rise & r_lo_ok & (r_phase_lo < c_min_phase)));
   assign w_ev_stuck  = w_active & ~w_rise & ({1'b0, r_cnt} == w_stuck_lim);
   assign w_ev_any    = w_ev_period | w_ev_glitch | w_ev_stuck;
   assign w_good_rise = w_in_meas & w_rise & ~w_ev_period;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = c_idle;
      end else begin
         case (r_state)
            c_idle: w_state_nxt = c_arm;
            c_arm: begin
               if (w_rise) begin
                  w_state_nxt = c_meas;
               end
            end
            c_meas: begin
               if (w_ev_stuck) begin
                  w_state_nxt = c_arm;
               end
            end
            default: w_state_nxt = c_idle;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_active  = 1'b0;
      w_in_meas = 1'b0;
      case (r_state)
         c_arm: begin
            w_active = enable;
         end
         c_meas: begin
            w_active  = enable;
            w_in_meas = enable;
         end
         default: ;
      endcase
   end

   // ---------------- synchronizer and edge detect ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], mon};
         r_prev <= w_sync;
      end
   end

   // ---------------- measurement datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_phase_lo   <= '0;
         r_hi_ok      <= 1'b0;
         r_lo_ok      <= 1'b0;
         r_good       <= '0;
         r_period     <= '0;
         r_high       <= '0;
         r_meas_valid <= 1'b0;
      end else if (!w_active) begin
         // Idle or leaving: discard partial measurement, keep results.
         r_cnt        <= '0;
         r_phase_lo   <= '0;
         r_hi_ok      <= 1'b0;
         r_lo_ok      <= 1'b0;
         r_good       <= '0;
         r_meas_valid <= 1'b0;
      end else begin
         r_meas_valid <= w_in_meas & w_rise;

         if (w_rise) begin
            r_cnt <= c_cnt_one;
         end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_fall) begin
            r_phase_lo <= c_cnt_one;
         end else if (r_phase_lo != c_cnt_max) begin
            r_phase_lo <= r_phase_lo + 1'b1;
         end

         if (w_rise) begin
            r_hi_ok <= 1'b1;
         end
         if (w_fall) begin
            r_lo_ok <= 1'b1;
         end

         if (w_in_meas & w_rise) begin
            r_period <= r_cnt;
         end
         if (w_in_meas & w_fall) begin
            r_high <= r_cnt;
         end

         if (w_ev_any) begin
            r_good <= '0;
         end else if (w_good_rise && (r_good != c_lock_n)) begin
            r_good <= r_good + 1'b1;
         end
      end
   end

   // ---------------- sticky error flags ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_period <= 1'b0;
         r_err_glitch <= 1'b0;
         r_err_stuck  <= 1'b0;
      end else begin
         r_err_period <= (r_err_period & ~clear) | w_ev_period;
         r_err_glitch <= (r_err_glitch & ~clear) | w_ev_glitch;
         r_err_stuck  <= (r_err_stuck  & ~clear) | w_ev_stuck;
      end
   end

   assign period     = r_period;
   assign high_cnt   = r_high;
   assign meas_valid = r_meas_valid;
   assign err_period = r_err_period;
   assign err_glitch = r_err_glitch;
   assign err_stuck  = r_err_stuck;
   assign locked     = (r_good == c_lock_n);

endmodule
`default_nettype wire

// File: tb/tb_clock_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_monitor
//  Brief    : Directed and randomized bench for clock_monitor with a
//             timestamp-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_monitor;

   localparam int STAGES    = 2;
   localparam int CW        = 16;
   localparam int MIN_PHASE = 2;
   localparam int LOCK_N    = 4;
   localparam int CMAX      = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mon = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [CW-1:0] per_min = 16'd18;
   logic [CW-1:0] per_max = 16'd22;
   logic [CW-1:0] period;
   logic [CW-1:0] high_cnt;
   logic          meas_valid;
   logic          err_period;
   logic          err_glitch;
   logic          err_stuck;
   logic          locked;

   int n_cmp   = 0;
   int n_bad   = 0;
   int mv_seen = 0;

   always #5 clk = ~clk;

   clock_monitor #(
      .STAGES(STAGES), .CW(CW), .MIN_PHASE(MIN_PHASE), .LOCK_N(LOCK_N)
   ) dut (
      .clk(clk), .rst(rst), .mon(mon), .enable(enable), .clear(clear),
      .per_min(per_min), .per_max(per_max),
      .period(period), .high_cnt(high_cnt), .meas_valid(meas_valid),
      .err_period(err_period), .err_glitch(err_glitch),
      .err_stuck(err_stuck), .locked(locked)
   );

   // ---------------- reference model ----------------
   // Phases are derived from timestamps of the last observed edges.
   int  cyc = 0;
   bit  m_ok = 1'b0;
   int  mode = 0;            // 0 idle, 1 armed, 2 measuring
   bit  mq[$];               // mon samples since reset, newest last
   int  t_base = 0;
   int  t_fall = 0;
   bit  hi_ok = 1'b0;
   bit  lo_ok = 1'b0;
   int  good = 0;
   int  e_period = 0;
   int  e_high = 0;
   bit  e_mv = 1'b0;
   bit  e_ep = 1'b0;
   bit  e_eg = 1'b0;
   bit  e_es = 1'b0;

   function automatic bit hist(int d);
      if (d <= mq.size()) return mq[mq.size() - d];
      return 1'b0;
   endfunction

   always @(posedge clk) begin : model
      bit s, p, r, f, evp, evg, evs;
      int c, pl;
      if (rst) begin
         mq.delete();
         mode = 0; good = 0; hi_ok = 0; lo_ok = 0; t_base = 0; t_fall = 0;
         e_period = 0; e_high = 0; e_mv = 0; e_ep = 0; e_eg = 0; e_es = 0;
         m_ok = 1'b1;
      end else begin
         s = hist(STAGES);
         p = hist(STAGES + 1);
         r = s & !p;
         f = !s & p;
         evp = 0; evg = 0; evs = 0;
         if (!enable) begin
            mode = 0; good = 0; e_mv = 0; hi_ok = 0; lo_ok = 0;
         end else if (mode == 0) begin
            mode = 1; t_base = cyc + 1; e_mv = 0; hi_ok = 0; lo_ok = 0;
         end else begin
            c  = cyc - t_base; if (c > CMAX) c = CMAX;
            pl = cyc - t_fall; if (pl > CMAX) pl = CMAX;
            evp = (mode == 2) && r && (c < int'(per_min) || c > int'(per_max));
            evg = (f && hi_ok && c < MIN_PHASE) || (r && lo_ok && pl < MIN_PHASE);
            evs = !r && (c == 2 * int'(per_max));
            e_mv = (mode == 2) && r;
            if (e_mv) e_period = c;
            if (mode == 2 && f) e_high = c;
            if (evp || evg || evs) good = 0;
            else if (mode == 2 && r && good < LOCK_N) good++;
            if (r) begin t_base = cyc; hi_ok = 1; end
            if (f) begin t_fall = cyc; lo_ok = 1; end
            if (evs) mode = 1;
            else if (mode == 1 && r) mode = 2;
         end
         e_ep = (e_ep & !clear) | evp;
         e_eg = (e_eg & !clear) | evg;
         e_es = (e_es & !clear) | evs;
         mq.push_back(mon);
         if (mq.size() > STAGES + 1) void'(mq.pop_front());
      end
      cyc++;
   end

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_ok) begin
         chk("period",     int'(period),     e_period);
         chk("high_cnt",   int'(high_cnt),   e_high);
         chk("meas_valid", int'(meas_valid), int'(e_mv));
         chk("err_period", int'(err_period), int'(e_ep));
         chk("err_glitch", int'(err_glitch), int'(e_eg));
         chk("err_stuck",  int'(err_stuck),  int'(e_es));
         chk("locked",     int'(locked),     int'(good == LOCK_N));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic mph(bit v, int n);
      mon = v;
      repeat (n) begin
         @(negedge clk);
         if (meas_valid) mv_seen++;
      end
   endtask

   task automatic per(int hi, int lo, int reps);
      repeat (reps) begin
         mph(1'b1, hi);
         mph(1'b0, lo);
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_period"}, int'(period), 0);
      chk({tag, "_high"},   int'(high_cnt), 0);
      chk({tag, "_mv"},     int'(meas_valid), 0);
      chk({tag, "_ep"},     int'(err_period), 0);
      chk({tag, "_eg"},     int'(err_glitch), 0);
      chk({tag, "_es"},     int'(err_stuck), 0);
      chk({tag, "_locked"}, int'(locked), 0);
   endtask

   initial begin
      int hi, lo, pmin;
      // reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      enable = 1'b1;

      // nominal 20-cycle clock
      per(10, 10, 2);
      mv_seen = 0;
      per(10, 10, 3);
      chk("nom_mv_count", mv_seen, 3);
      per(10, 10, 1);
      chk("nom_period", int'(period), 20);
      chk("nom_high", int'(high_cnt), 10);
      chk("nom_locked", int'(locked), 1);
      chk("nom_ep", int'(err_period), 0);
      chk("nom_eg", int'(err_glitch), 0);
      chk("nom_es", int'(err_stuck), 0);

      // out-of-range period, then clear colliding with a new error
      mph(1'b1, 15); mph(1'b0, 15);
      mph(1'b1, 3);
      chk("oor_period", int'(period), 30);
      chk("oor_err", int'(err_period), 1);
      chk("oor_locked", int'(locked), 0);
      mph(1'b1, 12); mph(1'b0, 15);
      mon = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      chk("clear_vs_event", int'(err_period), 1);
      @(negedge clk);
      chk("clear_no_event", int'(err_period), 0);
      clear = 1'b0;
      mph(1'b1, 11); mph(1'b0, 15);

      // relock, then glitch
      per(10, 10, 5);
      pulse_clear();
      chk("relock_ep", int'(err_period), 0);
      chk("relock_locked", int'(locked), 1);
      mph(1'b1, 10); mph(1'b0, 4); mph(1'b1, 1); mph(1'b0, 5);
      chk("glitch_flag", int'(err_glitch), 1);
      chk("glitch_locked", int'(locked), 0);
      per(10, 10, 6);
      chk("glitch_relock", int'(locked), 1);
      chk("glitch_sticky", int'(err_glitch), 1);
      pulse_clear();
      chk("glitch_cleared", int'(err_glitch), 0);

      // stuck low
      mph(1'b0, 40);
      chk("stuck_flag", int'(err_stuck), 1);
      chk("stuck_locked", int'(locked), 0);
      mv_seen = 0;
      per(10, 10, 1);
      chk("stuck_no_meas", mv_seen, 0);
      chk("stuck_period_held", int'(period), 20);
      chk("stuck_high", int'(high_cnt), 10);
      pulse_clear();
      chk("stuck_cleared", int'(err_stuck), 0);

      // reset mid-measurement, then enable drop
      per(10, 10, 5);
      mph(1'b1, 10);
      rst = 1'b1;
      mon = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      per(10, 10, 6);
      chk("post_rst_locked", int'(locked), 1);
      enable = 1'b0;
      @(negedge clk);
      chk("dis_locked", int'(locked), 0);
      chk("dis_period", int'(period), 20);
      chk("dis_high", int'(high_cnt), 10);
      enable = 1'b1;

      // inverted window: every measured period is an error
      per_min = 16'd25;
      per_max = 16'd15;
      per(10, 10, 3);
      chk("inv_err", int'(err_period), 1);
      chk("inv_locked", int'(locked), 0);

      // randomized traffic
      for (int i = 0; i < 220; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            pmin = $urandom_range(4, 24);
            per_min = CW'(pmin);
            per_max = CW'(pmin + $urandom_range(0, 12) - 2);
         end
         hi = $urandom_range(0, 13);
         lo = $urandom_range(1, 14);
         if ($urandom_range(0, 19) == 0) lo = $urandom_range(30, 70);
         if ($urandom_range(0, 7) == 0)  clear = 1'b1;
         if ($urandom_range(0, 29) == 0) enable = 1'b0;
         if ($urandom_range(0, 49) == 0) rst = 1'b1;
         mph(1'b1, 1);
         clear = 1'b0;
         rst = 1'b0;
         mph(1'b1, hi);
         enable = 1'b1;
         mph(1'b0, lo);
      end

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
